fifo_ram: RTL and testbench

Parametrised synchronous FIFO built on a dual-address RAM with registered read. It is the next-generation replacement for bare RAM buffering in the datapath. The block adds pointer management, occupancy count, full/empty/almost thresholds, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain.

---
 rtl/fifo_ram_pkg.sv | 22 ++
 rtl/fifo_ram_ram_dp.sv | 31 +++
 rtl/fifo_ram.sv | 109 ++++++++++
 tb/tb_fifo_ram.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fifo_ram_pkg.sv
// Shared helpers for fifo_ram: pointer width, depth and the parity used when
// FIFO_RAM_PARITY_EN is defined.
package fifo_ram_pkg;

    localparam int ADDR_BITS_DEF = 3;
    localparam int PTR_BITS_DEF  = ADDR_BITS_DEF + 1;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_bits(input int addr_bits);
        return addr_bits + 1;
    endfunction

    function automatic int depth(input int addr_bits);
        return 2 ** addr_bits;
    endfunction

    // Even parity over up to 32 data bits; callers zero-extend narrower words.
    function automatic logic even_par(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fifo_ram_ram_dp.sv
// Dual-address RAM: synchronous write, registered read with enable.
// Read-before-write on a same-address collision; only the read register resets.
module ram_dp #(
    parameter int W  = 10,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [2**AW];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (reset)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_ram.sv
// Synchronous FIFO over ram_dp with occupancy count, threshold flags and sticky
// error flags. Define FIFO_RAM_PARITY_EN to store and check even parity per word.
module fifo_ram
    import fifo_ram_pkg::*;
#(
    parameter int DATA_BITS       = 10,
    parameter int ADDR_BITS       = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow_err,
`ifdef FIFO_RAM_PARITY_EN
    output logic                 underflow_err,
    output logic                 parity_err
`else
    output logic                 underflow_err
`endif
);

    localparam int PTR_W = ptr_bits(ADDR_BITS);
    localparam int DEPTH = depth(ADDR_BITS);
`ifdef FIFO_RAM_PARITY_EN
    localparam int RAM_W = DATA_BITS + 1;
`else
    localparam int RAM_W = DATA_BITS;
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic             valid_q, ovf_q, ovf_d, unf_q, unf_d;
    logic             push_ok, pop_ok;
    logic [RAM_W-1:0] wdata, rdata;

    assign full         = (count_q == PTR_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= PTR_W'(ALMOST_FULL_TH));
    assign almost_empty = (count_q <= PTR_W'(ALMOST_EMPTY_TH));

    always_comb begin
        // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (push && full && !pop);
        unf_d = unf_q | (pop && empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= pop_ok;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef FIFO_RAM_PARITY_EN
    assign wdata      = {even_par(32'(data_in)), data_in};
    // A clean word XORs to zero including its stored parity bit.
    assign parity_err = valid_q && (^rdata);
`else
    assign wdata      = data_in;
`endif

    ram_dp #(.W(RAM_W), .AW(ADDR_BITS)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q[ADDR_BITS-1:0]),
        .wdata_i (wdata),
        .re_i    (pop_ok),
        .raddr_i (rd_ptr_q[ADDR_BITS-1:0]),
        .rdata_o (rdata)
    );

    assign data_out      = rdata[DATA_BITS-1:0];
    assign valid_out     = valid_q;
    assign count         = count_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_fifo_ram.sv
// Self-checking bench for fifo_ram: directed sequences plus random traffic,
// compared against a queue model. Covers FIFO_RAM_PARITY_EN when defined.
module tb_fifo_ram;
    localparam int DW = 10, AW = 3, DEPTH = 8, AF = 6, AE = 2;

    logic          clk = 1'b0, reset = 1'b0, push = 1'b0, pop = 1'b0;
    logic [DW-1:0] data_in = '0, data_out;
    logic          valid_out, full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow_err, underflow_err;
`ifdef FIFO_RAM_PARITY_EN
    logic          parity_err;
`endif

    fifo_ram #(.DATA_BITS(DW), .ADDR_BITS(AW), .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE)) dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow_err(overflow_err),
`ifdef FIFO_RAM_PARITY_EN
        .parity_err(parity_err),
`endif
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the FIFO contents as a queue plus the visible registers.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_vld = 0, m_ovf = 0, m_unf = 0;

    task automatic check_all(input bit perr_exp);
        int sz = mq.size();
        chk("count", 32'(count), 32'(sz));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("almost_full", 32'(almost_full), 32'(sz >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("valid_out", 32'(valid_out), 32'(m_vld));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
        chk("underflow_err", 32'(underflow_err), 32'(m_unf));
`ifdef FIFO_RAM_PARITY_EN
        chk("parity_err", 32'(parity_err), 32'(perr_exp));
`else
        if (perr_exp) chk("parity_unexpected", 32'(perr_exp), 32'd0);
`endif
    endtask

    task automatic step(input bit p, input bit q, input logic [DW-1:0] d, input bit perr_exp = 0);
        int sz;
        bit pok, wok;
        @(negedge clk);
        push = p; pop = q; data_in = d;
        sz  = mq.size();
        pok = q && (sz != 0);
        wok = p && (sz != DEPTH || q);
        if (q && sz == 0)              m_unf = 1;
        if (p && sz == DEPTH && !q)    m_ovf = 1;
        m_vld = pok;
        if (pok) m_dout = mq.pop_front();
        if (wok) mq.push_back(d);
        @(posedge clk); #1;
        check_all(perr_exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; push = 0; pop = 0;
        @(posedge clk); #1;
        reset = 0;
        mq.delete();
        m_dout = '0; m_vld = 0; m_ovf = 0; m_unf = 0;
        check_all(0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        step(0, 0, '0);

        // Fill to full, then a rejected push of 0x3FF, then drain in order.
        for (int i = 1; i <= 8; i++) step(1, 0, DW'(i));
        step(1, 0, 10'h3FF);
        for (int i = 0; i < 8; i++) step(0, 1, '0);

        // Underflow while empty, then simultaneous push+pop while empty.
        step(0, 1, '0);
        step(1, 1, 10'h055);
        step(0, 0, '0);

        // Top up to full and stream through the pointer wrap.
        for (int i = 0; i < 7; i++) step(1, 0, DW'(10'h100 + i));
        for (int i = 0; i < 20; i++) step(1, 1, DW'(10'h200 + i));
        for (int i = 0; i < 8; i++) step(0, 1, '0);

        // Reset mid-operation: stored words vanish, next push lands at address 0.
        do_reset();
        step(1, 0, 10'h0A1);
        step(1, 0, 10'h0A2);
        do_reset();
        step(1, 0, 10'h1C3);
        chk("first_push_addr0", 32'(dut.u_ram.mem_q[0][DW-1:0]), 32'h1C3);
        step(0, 1, '0);

        // Random traffic in phases biased toward filling and draining.
        for (int ph = 0; ph < 6; ph++) begin
            int pp = (ph % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 60; i++)
                step($urandom_range(99) < pp, $urandom_range(99) < (100 - pp),
                     DW'($urandom));
        end

`ifdef FIFO_RAM_PARITY_EN
        do_reset();
        step(1, 0, 10'h011);
        step(1, 0, 10'h022);
        step(1, 0, 10'h033);
        dut.u_ram.mem_q[1][DW] = ~dut.u_ram.mem_q[1][DW];
        step(0, 1, '0, 0);
        step(0, 1, '0, 1);
        step(0, 1, '0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
